dft_cfg_sequencer: RTL and testbench

// - Owns the per-object delay/obj-id configuration table and sequences its delivery to the DFT datapath.
// - On start: pulses load to the config shift registers, raises upload to start the DFT clock generator,

---
 rtl/dft_cfg_pkg.sv | 28 ++
 rtl/dft_cfg_table.sv | 45 ++++
 rtl/dft_cfg_sequencer.sv | 173 +++++++++++++++++
 tb/tb_dft_cfg_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dft_cfg_pkg.sv
// Shared definitions for the DFT configuration sequencer.
// Contents:
//   - default widths and depth of the delay/obj-id table
//   - the unused-slot sentinel value (all-ones delay) at default width
//   - 3-bit FSM state encoding and the state type built on it
package dft_cfg_pkg;

    localparam int DEF_DELAY_LENGTH = 14;
    localparam int DEF_OBJ_ID_WIDTH = 2;
    localparam int DEF_N_OBJ        = 4;

    localparam logic [DEF_DELAY_LENGTH-1:0] DEF_SENTINEL = {DEF_DELAY_LENGTH{1'b1}};

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_WAIT_RDY = 3'd2;
    localparam logic [2:0] ST_STREAM   = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_LOAD     = ST_LOAD,
        S_WAIT_RDY = ST_WAIT_RDY,
        S_STREAM   = ST_STREAM,
        S_DONE     = ST_DONE
    } state_t;

endpackage

// File: rtl/dft_cfg_table.sv
// N_obj-entry delay/obj-id register file.
// Ports:
//   CLK, reset          clock, synchronous active-high reset
//   wr_en/wr_addr       single write port (caller gates writes while busy)
//   wr_delay/wr_obj     data written to the addressed entry
//   rd_addr             asynchronous read index (stream pointer)
//   rd_delay/rd_obj     addressed entry contents
// Reset initialises every delay to all-ones (unused slot) and obj id to its index.
module dft_cfg_table
    import dft_cfg_pkg::*;
#(
    parameter int delay_length = DEF_DELAY_LENGTH,
    parameter int obj_id_width = DEF_OBJ_ID_WIDTH,
    parameter int N_obj        = DEF_N_OBJ
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [obj_id_width-1:0] wr_addr,
    input  logic [delay_length-1:0] wr_delay,
    input  logic [obj_id_width-1:0] wr_obj,
    input  logic [obj_id_width-1:0] rd_addr,
    output logic [delay_length-1:0] rd_delay,
    output logic [obj_id_width-1:0] rd_obj
);

    logic [delay_length-1:0] delay_mem [N_obj];
    logic [obj_id_width-1:0] obj_mem   [N_obj];

    always_ff @(posedge CLK) begin
        for (int i = 0; i < N_obj; i++) begin
            if (reset) begin
                delay_mem[i] <= {delay_length{1'b1}};
                obj_mem[i]   <= obj_id_width'(i);
            end else if (wr_en && (wr_addr == obj_id_width'(i))) begin
                delay_mem[i] <= wr_delay;
                obj_mem[i]   <= wr_obj;
            end
        end
    end

    assign rd_delay = delay_mem[rd_addr];
    assign rd_obj   = obj_mem[rd_addr];

endmodule

// File: rtl/dft_cfg_sequencer.sv
// Configuration sequencer for the DFT datapath.
// Ports:
//   CLK, reset                  clock, synchronous active-high reset
//   cfg_wr_*                    table write port (accepted only while idle)
//   start, abort                pass request / cancel
//   dft_ready, dft_tick         handshake and per-period strobe from the DFT clock generator
//   load, upload                shift-register load strobe, DFT clock enable
//   elem_valid/delay_out/obj_id_out  emitted table entry (held when not valid)
//   busy, done, err             status: not idle / pass complete pulse / error pulse
//   valid_count                 non-sentinel entries emitted by the last completed pass
// All outputs are registered.
module dft_cfg_sequencer
    import dft_cfg_pkg::*;
#(
    parameter int delay_length  = DEF_DELAY_LENGTH,
    parameter int obj_id_width  = DEF_OBJ_ID_WIDTH,
    parameter int N_obj         = DEF_N_OBJ,
    parameter int LOAD_CYCLES   = 2,
    parameter int READY_TIMEOUT = 64
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    cfg_wr_en,
    input  logic [obj_id_width-1:0] cfg_wr_addr,
    input  logic [delay_length-1:0] cfg_wr_delay,
    input  logic [obj_id_width-1:0] cfg_wr_obj,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    dft_ready,
    input  logic                    dft_tick,
    output logic                    load,
    output logic                    upload,
    output logic                    elem_valid,
    output logic [delay_length-1:0] delay_out,
    output logic [obj_id_width-1:0] obj_id_out,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [obj_id_width:0]   valid_count
);

    localparam logic [delay_length-1:0] SENTINEL = {delay_length{1'b1}};
    localparam int LCW = $clog2(LOAD_CYCLES + 1);
    localparam int TCW = $clog2(READY_TIMEOUT + 1);

    state_t                  state;
    logic [LCW-1:0]          load_cnt;
    logic [TCW-1:0]          tmo_cnt;
    logic [obj_id_width-1:0] idx;
    logic [obj_id_width:0]   shadow_count;
    logic [delay_length-1:0] rd_delay;
    logic [obj_id_width-1:0] rd_obj;
    logic                    rd_used;
    logic                    tbl_wr;

    // busy is the registered status, so a write in the same cycle start is
    // sampled in IDLE is still accepted.
    assign tbl_wr  = cfg_wr_en && !busy;
    assign rd_used = (rd_delay != SENTINEL);

    dft_cfg_table #(
        .delay_length (delay_length),
        .obj_id_width (obj_id_width),
        .N_obj        (N_obj)
    ) u_table (
        .CLK      (CLK),
        .reset    (reset),
        .wr_en    (tbl_wr),
        .wr_addr  (cfg_wr_addr),
        .wr_delay (cfg_wr_delay),
        .wr_obj   (cfg_wr_obj),
        .rd_addr  (idx),
        .rd_delay (rd_delay),
        .rd_obj   (rd_obj)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= S_IDLE;
            load_cnt     <= '0;
            tmo_cnt      <= '0;
            idx          <= '0;
            shadow_count <= '0;
            load         <= 1'b0;
            upload       <= 1'b0;
            elem_valid   <= 1'b0;
            delay_out    <= '0;
            obj_id_out   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            valid_count  <= '0;
        end else begin
            elem_valid <= 1'b0;
            done       <= 1'b0;
            err        <= cfg_wr_en && busy;

            // abort beats every transition, including start in IDLE
            if (abort) begin
                state  <= S_IDLE;
                load   <= 1'b0;
                upload <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state    <= S_LOAD;
                            load     <= 1'b1;
                            busy     <= 1'b1;
                            load_cnt <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (load_cnt == LCW'(LOAD_CYCLES - 1)) begin
                            state   <= S_WAIT_RDY;
                            load    <= 1'b0;
                            upload  <= 1'b1;
                            tmo_cnt <= '0;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                    S_WAIT_RDY: begin
                        if (dft_ready) begin
                            state        <= S_STREAM;
                            idx          <= '0;
                            shadow_count <= '0;
                        end else if (tmo_cnt == TCW'(READY_TIMEOUT - 1)) begin
                            state  <= S_IDLE;
                            upload <= 1'b0;
                            busy   <= 1'b0;
                            err    <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    S_STREAM: begin
                        // every tick consumes a slot; sentinel slots emit nothing
                        // so later entries keep their tick-aligned timing
                        if (dft_tick) begin
                            if (rd_used) begin
                                elem_valid <= 1'b1;
                                delay_out  <= rd_delay;
                                obj_id_out <= rd_obj;
                            end
                            idx <= idx + 1'b1;
                            if (idx == obj_id_width'(N_obj - 1)) begin
                                state       <= S_DONE;
                                upload      <= 1'b0;
                                done        <= 1'b1;
                                valid_count <= shadow_count + {{obj_id_width{1'b0}}, rd_used};
                            end else begin
                                shadow_count <= shadow_count + {{obj_id_width{1'b0}}, rd_used};
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        load   <= 1'b0;
                        upload <= 1'b0;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dft_cfg_sequencer.sv
// Testbench for dft_cfg_sequencer: scenario tasks against a slot-level table model.
module tb_dft_cfg_sequencer;

    localparam int DL = 14;
    localparam int OW = 2;
    localparam int NO = 4;
    localparam logic [DL-1:0] SENT = {DL{1'b1}};

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_wr_en = 1'b0;
    logic [OW-1:0] cfg_wr_addr = '0;
    logic [DL-1:0] cfg_wr_delay = '0;
    logic [OW-1:0] cfg_wr_obj = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          dft_ready = 1'b0;
    logic          dft_tick = 1'b0;
    logic          load, upload, elem_valid, busy, done, err;
    logic [DL-1:0] delay_out;
    logic [OW-1:0] obj_id_out;
    logic [OW:0]   valid_count;

    always #5 CLK = ~CLK;

    dft_cfg_sequencer dut (
        .CLK          (CLK),
        .reset        (reset),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_delay (cfg_wr_delay),
        .cfg_wr_obj   (cfg_wr_obj),
        .start        (start),
        .abort        (abort),
        .dft_ready    (dft_ready),
        .dft_tick     (dft_tick),
        .load         (load),
        .upload       (upload),
        .elem_valid   (elem_valid),
        .delay_out    (delay_out),
        .obj_id_out   (obj_id_out),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .valid_count  (valid_count)
    );

    int errors = 0;
    int checks = 0;

    // reference model: table contents and last completed-pass count
    logic [DL-1:0] m_delay [NO];
    logic [OW-1:0] m_obj   [NO];
    int            m_vcount;

    // per-pass observations
    int            load_cyc, upload_cyc, done_cnt, err_cnt;
    int            act_upload, act_busy, act_outs_zero, wr_err_seen, busy_after_err, upload_at_err;
    int            ev_cyc[$];
    logic [DL-1:0] ev_delay[$];
    logic [OW-1:0] ev_obj[$];
    int            xp_cyc[$];
    logic [DL-1:0] xp_delay[$];
    logic [OW-1:0] xp_obj[$];

    task automatic model_reset();
        for (int i = 0; i < NO; i++) begin
            m_delay[i] = SENT;
            m_obj[i]   = OW'(i);
        end
        m_vcount = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_wr_en = 1'b0;
        dft_ready = 1'b0; dft_tick = 1'b0;
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic write_entry(input int a, input logic [DL-1:0] d, input logic [OW-1:0] o);
        @(negedge CLK);
        cfg_wr_en = 1'b1; cfg_wr_addr = OW'(a); cfg_wr_delay = d; cfg_wr_obj = o;
        @(negedge CLK);
        cfg_wr_en = 1'b0;
        m_delay[a] = d;
        m_obj[a]   = o;
    endtask

    // mode: 0 normal, 1 abort after first elem_valid, 2 reset after first
    // elem_valid, 3 table write on the second tick. rdy_lat < 0: never ready.
    task automatic run_pass(input int rdy_lat, input int tick_per, input int mode);
        int n, up_seen, next_tick, slot, act_at, wr_at, err_at, end_at;
        bit seen_busy, acted, fin;
        n = 0; up_seen = 0; next_tick = -1; slot = 0; act_at = -10; wr_at = -10;
        err_at = -10; end_at = -1; seen_busy = 0; acted = 0; fin = 0;
        load_cyc = 0; upload_cyc = 0; done_cnt = 0; err_cnt = 0;
        act_upload = -1; act_busy = -1; act_outs_zero = -1; wr_err_seen = -1;
        busy_after_err = -1; upload_at_err = -1;
        ev_cyc.delete(); ev_delay.delete(); ev_obj.delete();
        xp_cyc.delete(); xp_delay.delete(); xp_obj.delete();
        @(negedge CLK);
        start = 1'b1;
        while (!fin) begin
            @(negedge CLK);
            n++;
            start = 1'b0; dft_tick = 1'b0; cfg_wr_en = 1'b0; abort = 1'b0; reset = 1'b0;
            if (load) load_cyc++;
            if (upload) upload_cyc++;
            if (done) done_cnt++;
            if (busy) seen_busy = 1;
            if (err) begin err_cnt++; err_at = n; upload_at_err = upload; end
            if (elem_valid) begin
                ev_cyc.push_back(n); ev_delay.push_back(delay_out); ev_obj.push_back(obj_id_out);
            end
            if (act_at == n - 1) begin
                act_upload = upload; act_busy = busy;
                act_outs_zero = ({load, upload, elem_valid, busy, done, err, valid_count,
                                  delay_out, obj_id_out} == '0);
            end
            if (wr_at == n - 1) wr_err_seen = err;
            if (err_at == n - 1) busy_after_err = busy;
            if (upload && next_tick < 0 && rdy_lat >= 0) begin
                up_seen++;
                if (up_seen == rdy_lat) begin
                    dft_ready = 1'b1;
                    next_tick = n + tick_per;
                end
            end
            if ((mode == 1 || mode == 2) && elem_valid && !acted) begin
                acted = 1; act_at = n;
                if (mode == 1) abort = 1'b1;
                else reset = 1'b1;
            end
            if (!acted && next_tick == n && slot < NO) begin
                dft_tick = 1'b1;
                if (m_delay[slot] != SENT) begin
                    xp_cyc.push_back(n + 1); xp_delay.push_back(m_delay[slot]); xp_obj.push_back(m_obj[slot]);
                end
                if (mode == 3 && slot == 1) begin
                    cfg_wr_en = 1'b1; cfg_wr_addr = 2'd1; cfg_wr_delay = 14'd5; cfg_wr_obj = 2'd2;
                    wr_at = n;
                end
                slot++;
                next_tick = n + tick_per;
            end
            if (seen_busy && !busy && end_at < 0) end_at = n + 3;
            if (n == end_at) fin = 1;
            if (n >= 400) begin
                checks++; errors++;
                $display("FAIL pass_budget: pass still running after %0d cycles, required to finish", n);
                fin = 1;
            end
        end
        dft_ready = 1'b0;
        if (mode == 0 || mode == 3) m_vcount = xp_cyc.size();
        if (mode == 2) model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({load, upload, elem_valid, busy, done, err, valid_count, delay_out, obj_id_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got load=%b upload=%b ev=%b busy=%b done=%b err=%b vc=%0d d=%0h o=%0d, required all 0",
                     load, upload, elem_valid, busy, done, err, valid_count, delay_out, obj_id_out);
        end
    endtask

    task automatic test_nominal();
        write_entry(0, 14'd10000, 2'd0);
        write_entry(1, 14'd10010, 2'd1);
        write_entry(2, SENT, 2'd2);
        write_entry(3, SENT, 2'd3);
        run_pass(3, 4, 0);
        checks++;
        if (load_cyc !== 2) begin errors++; $display("FAIL nominal_load: load high %0d cycles, required 2", load_cyc); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL nominal_done: %0d done pulses, required 1", done_cnt); end
        checks++;
        if (valid_count !== 3'd2) begin errors++; $display("FAIL nominal_vcount: got %0d, required 2", valid_count); end
        checks++;
        if (ev_cyc.size() !== xp_cyc.size()) begin
            errors++; $display("FAIL nominal_events: got %0d pulses, required %0d", ev_cyc.size(), xp_cyc.size());
        end else foreach (xp_cyc[i]) begin
            checks++;
            if (ev_cyc[i] !== xp_cyc[i] || ev_delay[i] !== xp_delay[i] || ev_obj[i] !== xp_obj[i]) begin
                errors++;
                $display("FAIL nominal_elem%0d: got cyc=%0d d=%0d o=%0d, required cyc=%0d d=%0d o=%0d", i,
                         ev_cyc[i], ev_delay[i], ev_obj[i], xp_cyc[i], xp_delay[i], xp_obj[i]);
            end
        end
    endtask

    task automatic test_sentinel_timing();
        int first;
        for (int i = 0; i < NO; i++) write_entry(i, DL'(i + 1), OW'(i));
        run_pass(2, 4, 0);
        checks++;
        if (ev_cyc.size() !== 4) begin
            errors++; $display("FAIL sent_full_count: got %0d pulses, required 4", ev_cyc.size());
        end else begin
            first = ev_cyc[0];
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (ev_cyc[i] - ev_cyc[i-1] !== 4 || ev_delay[i] !== DL'(i + 1)) begin
                    errors++; $display("FAIL sent_full_spacing%0d: got gap %0d d=%0d, required gap 4 d=%0d",
                                       i, ev_cyc[i] - ev_cyc[i-1], ev_delay[i], i + 1);
                end
            end
            write_entry(2, SENT, 2'd2);
            run_pass(2, 4, 0);
            checks++;
            if (ev_cyc.size() !== 3) begin
                errors++; $display("FAIL sent_hole_count: got %0d pulses, required 3", ev_cyc.size());
            end else begin
                checks++;
                if (ev_cyc[2] - ev_cyc[0] !== 12 || ev_delay[2] !== 14'd4 || ev_cyc[0] !== first) begin
                    errors++; $display("FAIL sent_hole_slot: got offset %0d d=%0d start=%0d, required offset 12 d=4 start=%0d",
                                       ev_cyc[2] - ev_cyc[0], ev_delay[2], ev_cyc[0], first);
                end
            end
            checks++;
            if (valid_count !== 3'd3) begin errors++; $display("FAIL sent_hole_vcount: got %0d, required 3", valid_count); end
        end
    endtask

    task automatic test_ready_timeout();
        int vc0;
        vc0 = m_vcount;
        run_pass(-1, 4, 0);
        m_vcount = vc0;
        checks++;
        if (upload_cyc !== 64) begin errors++; $display("FAIL tmo_upload: upload high %0d cycles, required 64", upload_cyc); end
        checks++;
        if (err_cnt !== 1 || upload_at_err !== 0) begin
            errors++; $display("FAIL tmo_err: got %0d err pulses upload=%0d at err, required 1 and 0", err_cnt, upload_at_err);
        end
        checks++;
        if (busy_after_err !== 0 || done_cnt !== 0) begin
            errors++; $display("FAIL tmo_end: got busy=%0d after err, done=%0d, required 0 and 0", busy_after_err, done_cnt);
        end
        checks++;
        if (valid_count !== 3'(m_vcount)) begin errors++; $display("FAIL tmo_vcount: got %0d, required %0d", valid_count, m_vcount); end
    endtask

    task automatic test_write_while_busy();
        write_entry(0, 14'd10000, 2'd0);
        write_entry(1, 14'd10010, 2'd1);
        write_entry(2, SENT, 2'd2);
        write_entry(3, SENT, 2'd3);
        run_pass(3, 4, 3);
        checks++;
        if (wr_err_seen !== 1 || err_cnt !== 1) begin
            errors++; $display("FAIL wr_busy_err: got err=%0d after write (%0d pulses), required 1 (1)", wr_err_seen, err_cnt);
        end
        run_pass(1, 3, 0);
        checks++;
        if (ev_cyc.size() !== 2) begin
            errors++; $display("FAIL wr_busy_count: got %0d pulses, required 2", ev_cyc.size());
        end else begin
            checks++;
            if (ev_delay[1] !== 14'd10010 || ev_obj[1] !== 2'd1 || ev_cyc[1] !== xp_cyc[1]) begin
                errors++; $display("FAIL wr_busy_slot1: got d=%0d o=%0d cyc=%0d, required d=10010 o=1 cyc=%0d",
                                   ev_delay[1], ev_obj[1], ev_cyc[1], xp_cyc[1]);
            end
        end
    endtask

    task automatic test_abort();
        run_pass(2, 3, 1);
        checks++;
        if (act_upload !== 0 || act_busy !== 0) begin
            errors++; $display("FAIL abort_next: got upload=%0d busy=%0d, required 0 0", act_upload, act_busy);
        end
        checks++;
        if (done_cnt !== 0 || ev_cyc.size() !== 1) begin
            errors++; $display("FAIL abort_done: got done=%0d pulses=%0d, required 0 and 1", done_cnt, ev_cyc.size());
        end
        checks++;
        if (valid_count !== 3'(m_vcount)) begin errors++; $display("FAIL abort_vcount: got %0d, required %0d", valid_count, m_vcount); end
        @(negedge CLK);
        start = 1'b1; abort = 1'b1;
        @(negedge CLK);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 0 || load !== 0) begin errors++; $display("FAIL abort_collision: got busy=%b load=%b, required 0 0", busy, load); end
        @(negedge CLK);
        checks++;
        if (busy !== 0) begin errors++; $display("FAIL abort_collision_hold: got busy=%b, required 0", busy); end
    endtask

    task automatic test_reset_mid_stream();
        run_pass(2, 4, 2);
        checks++;
        if (act_outs_zero !== 1) begin errors++; $display("FAIL rst_mid_outputs: got all-zero=%0d, required 1", act_outs_zero); end
        run_pass(2, 2, 0);
        checks++;
        if (ev_cyc.size() !== 0 || done_cnt !== 1 || valid_count !== 3'd0) begin
            errors++; $display("FAIL rst_mid_rerun: got pulses=%0d done=%0d vc=%0d, required 0 1 0",
                               ev_cyc.size(), done_cnt, valid_count);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < NO; i++)
                write_entry(i, ($urandom_range(0, 3) == 0) ? SENT : DL'($urandom_range(0, 16382)), OW'($urandom));
            run_pass(int'($urandom_range(1, 8)), int'($urandom_range(1, 6)), 0);
            checks++;
            if (done_cnt !== 1 || valid_count !== 3'(m_vcount)) begin
                errors++; $display("FAIL rand%0d_done: got done=%0d vc=%0d, required 1 %0d", it, done_cnt, valid_count, m_vcount);
            end
            checks++;
            if (ev_cyc.size() !== xp_cyc.size()) begin
                errors++; $display("FAIL rand%0d_count: got %0d pulses, required %0d", it, ev_cyc.size(), xp_cyc.size());
            end else foreach (xp_cyc[i]) begin
                checks++;
                if (ev_cyc[i] !== xp_cyc[i] || ev_delay[i] !== xp_delay[i] || ev_obj[i] !== xp_obj[i]) begin
                    errors++;
                    $display("FAIL rand%0d_elem%0d: got cyc=%0d d=%0d o=%0d, required cyc=%0d d=%0d o=%0d", it, i,
                             ev_cyc[i], ev_delay[i], ev_obj[i], xp_cyc[i], xp_delay[i], xp_obj[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_sentinel_timing();
        test_ready_timeout();
        test_write_while_busy();
        test_abort();
        test_reset_mid_stream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
